// File: rtl/alu_iq.sv
// ALU issue queue: age-ordered, compacting, wakeup-aware, single issue per cycle.

package core_types_pkg;
    parameter int LOG_PR_COUNT       = 6;
    parameter int LOG_PRF_BANK_COUNT = 2;
endpackage

module alu_iq
    import core_types_pkg::*;
#(
    parameter int IQ_ENTRIES = 4
) (
    input  logic                          CLK,
    input  logic                          nRST,

    input  logic                          dispatch_valid_in,
    input  logic [3:0]                    dispatch_op_in,
    input  logic                          dispatch_is_imm_in,
    input  logic [31:0]                   dispatch_imm_in,
    input  logic                          dispatch_A_unneeded_in,
    input  logic [LOG_PR_COUNT-1:0]       dispatch_A_PR_in,
    input  logic                          dispatch_A_ready_in,
    input  logic [LOG_PR_COUNT-1:0]       dispatch_B_PR_in,
    input  logic                          dispatch_B_ready_in,
    input  logic [LOG_PR_COUNT-1:0]       dispatch_dest_PR_in,
    output logic                          dispatch_ready_out,

    input  logic                          wakeup_valid_in,
    input  logic [LOG_PR_COUNT-1:0]       wakeup_PR_in,

    input  logic                          pipeline_ready_in,

    output logic                          issue_valid_out,
    output logic [3:0]                    issue_op_out,
    output logic                          issue_is_imm_out,
    output logic [31:0]                   issue_imm_out,
    output logic                          issue_A_unneeded_out,
    output logic [LOG_PR_COUNT-1:0]       issue_dest_PR_out,
    output logic                          issue_A_forward_out,
    output logic                          issue_B_forward_out,
    output logic [LOG_PRF_BANK_COUNT-1:0] issue_A_bank_out,
    output logic [LOG_PRF_BANK_COUNT-1:0] issue_B_bank_out,

    output logic                          PRF_req_A_valid_out,
    output logic [LOG_PR_COUNT-1:0]       PRF_req_A_PR_out,
    output logic                          PRF_req_B_valid_out,
    output logic [LOG_PR_COUNT-1:0]       PRF_req_B_PR_out
);

    localparam int LOG_IQ = $clog2(IQ_ENTRIES);

    typedef struct packed {
        logic                    valid;
        logic [3:0]              op;
        logic                    is_imm;
        logic [31:0]             imm;
        logic                    A_unneeded;
        logic [LOG_PR_COUNT-1:0] A_PR;
        logic                    A_ready;
        logic [LOG_PR_COUNT-1:0] B_PR;
        logic                    B_ready;
        logic [LOG_PR_COUNT-1:0] dest_PR;
    } iq_entry_t;

    iq_entry_t [IQ_ENTRIES-1:0] entries;
    iq_entry_t [IQ_ENTRIES-1:0] entries_woken;
    iq_entry_t [IQ_ENTRIES-1:0] entries_next;
    iq_entry_t                  sel_entry;
    iq_entry_t                  new_entry;

    logic [LOG_IQ:0]            count;
    logic [LOG_IQ:0]            count_next;
    logic [LOG_IQ:0]            tail;
    logic [IQ_ENTRIES-1:0]      a_wake;
    logic [IQ_ENTRIES-1:0]      b_wake;
    logic [IQ_ENTRIES-1:0]      issuable;
    logic [LOG_IQ-1:0]          sel;
    logic                       any_issuable;
    logic                       accept;

    // Per-entry wakeup match and issue eligibility (wakeup counts this cycle).
    genvar gi;
    generate
        for (gi = 0; gi < IQ_ENTRIES; gi++) begin : g_ent
            assign a_wake[gi]   = wakeup_valid_in && (wakeup_PR_in == entries[gi].A_PR);
            assign b_wake[gi]   = wakeup_valid_in && (wakeup_PR_in == entries[gi].B_PR);
            assign issuable[gi] = entries[gi].valid
                                  && (entries[gi].A_unneeded || entries[gi].A_ready || a_wake[gi])
                                  && (entries[gi].is_imm     || entries[gi].B_ready || b_wake[gi]);
        end
    endgenerate

    // Oldest-first select: lowest issuable index wins.
    always_comb begin
        sel          = '0;
        any_issuable = 1'b0;
        for (int i = IQ_ENTRIES - 1; i >= 0; i--) begin
            if (issuable[i]) begin
                sel          = i[LOG_IQ-1:0];
                any_issuable = 1'b1;
            end
        end
    end

    assign sel_entry            = entries[sel];
    assign dispatch_ready_out   = (count < (LOG_IQ+1)'(IQ_ENTRIES));
    assign issue_valid_out      = pipeline_ready_in && any_issuable && nRST;
    assign issue_op_out         = sel_entry.op;
    assign issue_is_imm_out     = sel_entry.is_imm;
    assign issue_imm_out        = sel_entry.imm;
    assign issue_A_unneeded_out = sel_entry.A_unneeded;
    assign issue_dest_PR_out    = sel_entry.dest_PR;
    // Forward only when the operand was waiting and this cycle's writeback is what frees it.
    assign issue_A_forward_out  = !sel_entry.A_unneeded && !sel_entry.A_ready && a_wake[sel];
    assign issue_B_forward_out  = !sel_entry.is_imm && !sel_entry.B_ready && b_wake[sel];
    assign issue_A_bank_out     = sel_entry.A_PR[LOG_PRF_BANK_COUNT-1:0];
    assign issue_B_bank_out     = sel_entry.B_PR[LOG_PRF_BANK_COUNT-1:0];
    assign PRF_req_A_valid_out  = issue_valid_out && !sel_entry.A_unneeded && !issue_A_forward_out;
    assign PRF_req_B_valid_out  = issue_valid_out && !sel_entry.is_imm && !issue_B_forward_out;
    assign PRF_req_A_PR_out     = sel_entry.A_PR;
    assign PRF_req_B_PR_out     = sel_entry.B_PR;

    assign accept = dispatch_valid_in && dispatch_ready_out;
    assign tail   = count - (LOG_IQ+1)'(issue_valid_out);

    // Incoming entry captures a same-cycle wakeup so it is never missed.
    always_comb begin
        new_entry            = '0;
        new_entry.valid      = 1'b1;
        new_entry.op         = dispatch_op_in;
        new_entry.is_imm     = dispatch_is_imm_in;
        new_entry.imm        = dispatch_imm_in;
        new_entry.A_unneeded = dispatch_A_unneeded_in;
        new_entry.A_PR       = dispatch_A_PR_in;
        new_entry.A_ready    = dispatch_A_ready_in
                               || (wakeup_valid_in && wakeup_PR_in == dispatch_A_PR_in);
        new_entry.B_PR       = dispatch_B_PR_in;
        new_entry.B_ready    = dispatch_B_ready_in
                               || (wakeup_valid_in && wakeup_PR_in == dispatch_B_PR_in);
        new_entry.dest_PR    = dispatch_dest_PR_in;
    end

    // Next queue image: apply wakeups, compact out the issued slot, then append at the new tail.
    always_comb begin
        entries_woken = entries;
        for (int i = 0; i < IQ_ENTRIES; i++) begin
            if (a_wake[i]) entries_woken[i].A_ready = 1'b1;
            if (b_wake[i]) entries_woken[i].B_ready = 1'b1;
        end
        entries_next = entries_woken;
        if (issue_valid_out) begin
            for (int i = 0; i < IQ_ENTRIES - 1; i++) begin
                if (i >= int'(sel)) entries_next[i] = entries_woken[i+1];
            end
            entries_next[IQ_ENTRIES-1] = '0;
        end
        if (accept) entries_next[tail[LOG_IQ-1:0]] = new_entry;
        count_next = count + (LOG_IQ+1)'(accept) - (LOG_IQ+1)'(issue_valid_out);
    end

    // Queue state register with synchronous clear.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            entries <= '0;
            count   <= '0;
        end else begin
            entries <= entries_next;
            count   <= count_next;
        end
    end

endmodule
